// File: rtl/seg_scan_display_pkg.sv
// Shared constants for the multiplexed seven-segment scanner.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: hex digit segment patterns (gfedcba), segment bit indices, all-off pattern.
package seg_pkg;

    typedef logic [7:0] seg_t;

    // Segment bit positions inside seg_t.
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Hex glyphs, bit 6 = g ... bit 0 = a.
    localparam logic [6:0] HEX_0 = 7'b0111111;
    localparam logic [6:0] HEX_1 = 7'b0000110;
    localparam logic [6:0] HEX_2 = 7'b1011011;
    localparam logic [6:0] HEX_3 = 7'b1001111;
    localparam logic [6:0] HEX_4 = 7'b1100110;
    localparam logic [6:0] HEX_5 = 7'b1101101;
    localparam logic [6:0] HEX_6 = 7'b1111101;
    localparam logic [6:0] HEX_7 = 7'b0000111;
    localparam logic [6:0] HEX_8 = 7'b1111111;
    localparam logic [6:0] HEX_9 = 7'b1101111;
    localparam logic [6:0] HEX_A = 7'b1110111;
    localparam logic [6:0] HEX_B = 7'b1111100;
    localparam logic [6:0] HEX_C = 7'b0111001;
    localparam logic [6:0] HEX_D = 7'b1011110;
    localparam logic [6:0] HEX_E = 7'b1111001;
    localparam logic [6:0] HEX_F = 7'b1110001;

    // Every segment and the decimal point dark, in active-high polarity.
    localparam seg_t SEG_ALL_OFF = 8'h00;

endpackage

// File: rtl/seg_scan_display_if.sv
// Display request/drive bundle between the host logic and the segment scanner.
// Latency: n/a (wires only).
// Backpressure: none; the display consumes whatever is presented every cycle.
// Signals: enable, num (4 bits per digit, digit 0 in num[3:0]), dp, blink_sel in;
//          anode (active-low digit enables), seg (a..g, dp) out.
interface seg_scan_display_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    enable;
    logic [4*NUM_DIGITS-1:0] num;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blink_sel;
    logic [NUM_DIGITS-1:0]   anode;
    logic [7:0]              seg;

    modport master (
        output enable, num, dp, blink_sel,
        input  anode, seg
    );

    modport slave (
        input  enable, num, dp, blink_sel,
        output anode, seg
    );
endinterface

// File: rtl/seg_scan_display_hex_decoder.sv
// Hex nibble to seven-segment glyph decoder (module seg_hex_decoder).
// Latency: combinational.
// Backpressure: none.
// Ports: hex (4-bit nibble in), pat (7-bit gfedcba pattern out, active-high).
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] pat
);

    always_comb begin
        pat = HEX_0;
        case (hex)
            4'h0: pat = HEX_0;
            4'h1: pat = HEX_1;
            4'h2: pat = HEX_2;
            4'h3: pat = HEX_3;
            4'h4: pat = HEX_4;
            4'h5: pat = HEX_5;
            4'h6: pat = HEX_6;
            4'h7: pat = HEX_7;
            4'h8: pat = HEX_8;
            4'h9: pat = HEX_9;
            4'hA: pat = HEX_A;
            4'hB: pat = HEX_B;
            4'hC: pat = HEX_C;
            4'hD: pat = HEX_D;
            4'hE: pat = HEX_E;
            4'hF: pat = HEX_F;
            default: pat = HEX_0;
        endcase
    end

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed seven-segment scanner with anti-ghost blanking and per-digit blink.
// Latency: 1 cycle from counters/inputs to registered anode/seg.
// Backpressure: none; counters free-run, enable only gates the outputs.
// Ports: clk, reset (synchronous, active-high), disp (seg_scan_display_if.slave).
// Optional: define SEG_SCAN_LZB_EN for leading-zero blanking of digits above digit 0.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 65536,
    parameter int BLANK_CYCLES   = 256,
    parameter int BLINK_FRAMES   = 64,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic               clk,
    input  logic               reset,
    seg_scan_display_if.slave  disp
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    // XOR mask that is also the "dark" value in the output polarity.
    localparam seg_t SEG_OFF = (SEG_ACTIVE_LOW != 0) ? ~SEG_ALL_OFF : SEG_ALL_OFF;

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic [FW-1:0]         frame;
    logic                  phase_on;
    logic [NUM_DIGITS-1:0] anode_q;
    seg_t                  seg_q;

    logic [3:0]            digit;
    logic [6:0]            hex_pat;
    logic                  lz_blank;
    logic                  lit;
    logic [NUM_DIGITS-1:0] anode_nxt;
    seg_t                  seg_nxt;

    assign digit = disp.num[{idx, 2'b00} +: 4];

    seg_hex_decoder u_hex (
        .hex (digit),
        .pat (hex_pat)
    );

`ifdef SEG_SCAN_LZB_EN
    // lz_mask[i] is set when digit i and every digit above it are zero with no dp.
    logic [NUM_DIGITS-1:0] lz_mask;

    always_comb begin : lz_scan
        logic run;
        run     = 1'b1;
        lz_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run        = run && (disp.num[4*i +: 4] == 4'h0) && !disp.dp[i];
            lz_mask[i] = run;
        end
    end

    assign lz_blank = lz_mask[idx];
`else
    assign lz_blank = 1'b0;
`endif

    // Blanking window comes first in every slot so the previous digit's
    // segments never bleed onto the next anode.
    assign lit = disp.enable
              && (presc >= BLANK_END)
              && !(!phase_on && disp.blink_sel[idx])
              && !lz_blank;

    assign anode_nxt = lit ? ~(NUM_DIGITS'(1) << idx) : '1;
    assign seg_nxt   = lit ? ({disp.dp[idx], hex_pat} ^ SEG_OFF) : SEG_OFF;

    always_ff @(posedge clk) begin
        if (reset) begin
            presc    <= '0;
            idx      <= '0;
            frame    <= '0;
            phase_on <= 1'b1;
            anode_q  <= '1;
            seg_q    <= SEG_OFF;
        end else begin
            anode_q <= anode_nxt;
            seg_q   <= seg_nxt;
            if (presc == PRESC_LAST) begin
                presc <= '0;
                if (idx == IDX_LAST) begin
                    idx <= '0;
                    if (frame == FRAME_LAST) begin
                        frame    <= '0;
                        phase_on <= ~phase_on;
                    end else begin
                        frame <= frame + 1'b1;
                    end
                end else begin
                    idx <= idx + 1'b1;
                end
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    assign disp.anode = anode_q;
    assign disp.seg   = seg_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display with a 4-digit, 4-cycle-slot, 2-frame-blink build.
// Expected anode/seg words are queued at each clock edge from a cycle-count model
// and popped one time unit later against the registered DUT outputs.
module tb_seg_scan_display;

    logic clk;
    logic reset;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;

    logic [11:0] sb_q[$];
    logic [11:0] exp_v;
    logic [11:0] got_v;

    logic [6:0] hex_tbl [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    seg_scan_display_if #(.NUM_DIGITS(4)) disp_if ();

    seg_scan_display #(
        .NUM_DIGITS     (4),
        .SCAN_DIV       (4),
        .BLANK_CYCLES   (1),
        .BLINK_FRAMES   (2),
        .SEG_ACTIVE_LOW (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .disp  (disp_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected {anode, seg} for the c-th clock since reset release.
    function automatic logic [11:0] model(input int c, input logic en, input logic [15:0] n,
                                          input logic [3:0] d, input logic [3:0] b);
        int   p;
        int   ix;
        logic on;
        logic lit;
        logic [3:0] nib;
        p   = c % 4;
        ix  = (c / 4) % 4;
        on  = ((c / 32) % 2) == 0;
        lit = en && (p >= 1) && !(!on && b[ix]);
`ifdef SEG_SCAN_LZB_EN
        if (ix > 0) begin
            logic blank;
            blank = 1'b1;
            for (int j = ix; j < 4; j++)
                if (n[4*j +: 4] != 4'h0 || d[j]) blank = 1'b0;
            if (blank) lit = 1'b0;
        end
`endif
        nib = n[4*ix +: 4];
        if (lit) return {~(4'b0001 << ix), d[ix], hex_tbl[nib]};
        return {4'hF, 8'h00};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            exp_v = {4'hF, 8'h00};
            cyc   = 0;
        end else begin
            exp_v = model(cyc, disp_if.enable, disp_if.num, disp_if.dp, disp_if.blink_sel);
            cyc++;
        end
        sb_q.push_back(exp_v);
        #1;
        got_v = {disp_if.anode, disp_if.seg};
        check("scan", got_v, sb_q.pop_front());
    end

    initial begin
        int guard;
        reset             = 1'b1;
        disp_if.enable    = 1'b1;
        disp_if.num       = 16'h1234;
        disp_if.dp        = 4'b0000;
        disp_if.blink_sel = 4'b0000;

        repeat (3) @(negedge clk);
        reset = 1'b0;

        // First slot: one blank cycle, then digit 0 ('4').
        @(posedge clk); #2;
        check("rst_rel_an", {8'h0, disp_if.anode}, 12'h00F);
        @(posedge clk); #2;
        check("slot0_an",  {8'h0, disp_if.anode}, 12'h00E);
        check("slot0_seg", {4'h0, disp_if.seg},   12'h066);
        repeat (4) @(posedge clk); #2;
        check("slot1_an",  {8'h0, disp_if.anode}, 12'h00D);
        check("slot1_seg", {4'h0, disp_if.seg},   12'h04F);
        repeat (30) @(negedge clk);

        // Blinking cursor on digit 0 across several frames.
        disp_if.blink_sel = 4'b0001;
        repeat (96) @(negedge clk);
        disp_if.blink_sel = 4'b0000;

        // Letters and a decimal point.
        disp_if.num = 16'hABCF;
        disp_if.dp  = 4'b0100;
        repeat (20) @(negedge clk);

        // Reset landing in slot 2.
        guard = 0;
        while ((cyc % 16) != 9 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("slot2_wait", {11'h0, guard >= 100}, 12'h000);
        reset = 1'b1;
        @(posedge clk); #2;
        check("mid_rst", {disp_if.anode, disp_if.seg}, 12'hF00);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #2;
        check("post_rst_blank", {8'h0, disp_if.anode}, 12'h00F);
        @(posedge clk); #2;
        check("post_rst_dig0", {disp_if.anode, disp_if.seg}, 12'hE71);
        repeat (10) @(negedge clk);

        // Disable for 5 cycles mid-slot.
        @(negedge clk);
        disp_if.enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #2;
            check("dis_an", {8'h0, disp_if.anode}, 12'h00F);
        end
        @(negedge clk);
        disp_if.enable = 1'b1;
        repeat (20) @(negedge clk);

        // Leading zeros.
        disp_if.num = 16'h0050;
        disp_if.dp  = 4'b0000;
        repeat (20) @(negedge clk);

        // Inputs changing every cycle.
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            disp_if.num       = 16'($urandom);
            disp_if.dp        = 4'($urandom);
            disp_if.blink_sel = 4'($urandom);
            disp_if.enable    = ($urandom_range(0, 7) != 0);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
